// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: instruction constants and the fetch-stage state encoding.
package mips_pkg;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_fetch_stage_ifid_reg.sv
// Generic pipeline register (IF/ID style): flush loads a bubble, hold freezes, load captures.
module ifid_reg
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        flush_i,
    input  logic        hold_i,
    input  logic        load_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_plus4_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_plus4_o
);

    logic        valid_q,    valid_d;
    logic [31:0] instr_q,    instr_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;

    // A bubble keeps the old PC+4 so downstream debug still sees the last real link value.
    always_comb begin
        valid_d    = valid_q;
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        if (flush_i) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end else if (load_i && !hold_i) begin
            valid_d    = 1'b1;
            instr_d    = instr_i;
            pc_plus4_d = pc_plus4_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= 1'b0;
            instr_q    <= NOP_INSTR;
            pc_plus4_q <= 32'h0;
        end else begin
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
        end
    end

    assign valid_o    = valid_q;
    assign instr_o    = instr_q;
    assign pc_plus4_o = pc_plus4_q;

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: PC, boot wait, stall/redirect handling and sticky fetch fault.
module if_fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned IMEM_DEPTH  = 32,
    parameter int unsigned BOOT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc_plus4,
    output logic        fetch_fault,
    output logic [1:0]  fetch_state
);

    localparam logic [31:0] PC_LIMIT  = 32'(IMEM_DEPTH * WORD_BYTES);
    localparam logic [3:0]  BOOT_LAST = 4'(BOOT_CYCLES - 1);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [3:0]   boot_cnt_q, boot_cnt_d;
    logic         fault_q, fault_d;
    logic         pc_bad, pc_plus4;
    logic [31:0]  pc_next_seq;
    logic         flush, hold, load;

    assign pc_next_seq = pc_q + 32'(WORD_BYTES);
    assign pc_bad      = (pc_q[1:0] != 2'b00) || (pc_q >= PC_LIMIT);
    assign pc_plus4    = 1'b0;

    // Fault check outranks redirect, which outranks stall; a bad redirect target faults next cycle.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        boot_cnt_d = boot_cnt_q;
        fault_d    = fault_q;
        flush      = 1'b0;
        hold       = 1'b1;
        load       = 1'b0;
        case (state_q)
            BOOT: begin
                boot_cnt_d = boot_cnt_q + 4'd1;
                if (boot_cnt_q == BOOT_LAST) state_d = RUN;
            end
            RUN: begin
                if (pc_bad) begin
                    fault_d = 1'b1;
                    flush   = 1'b1;
                    state_d = HALT;
                end else if (redirect_en) begin
                    pc_d  = redirect_pc;
                    flush = 1'b1;
                end else if (!stall) begin
                    hold = 1'b0;
                    load = 1'b1;
                    pc_d = pc_next_seq;
                end
            end
            HALT: begin
            end
            default: state_d = HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            boot_cnt_q <= 4'd0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            boot_cnt_q <= boot_cnt_d;
            fault_q    <= fault_d;
        end
    end

    ifid_reg u_ifid (
        .clk        (clk),
        .reset      (reset),
        .flush_i    (flush | pc_plus4),
        .hold_i     (hold),
        .load_i     (load),
        .instr_i    (imem_data),
        .pc_plus4_i (pc_next_seq),
        .valid_o    (ifid_valid),
        .instr_o    (ifid_instr),
        .pc_plus4_o (ifid_pc_plus4)
    );

    assign imem_addr   = pc_q;
    assign fetch_fault = fault_q;
    assign fetch_state = state_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed vector table, hand sequences and a randomized run against a reference model.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        reset, stall, redirect_en;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr, imem_data;
    logic        ifid_valid, fetch_fault;
    logic [31:0] ifid_instr, ifid_pc_plus4;
    logic [1:0]  fetch_state;

    logic [31:0] imem_addr2, imem_data2;
    logic        ifid_valid2, fetch_fault2;
    logic [31:0] ifid_instr2, ifid_pc_plus42;
    logic [1:0]  fetch_state2;

    logic [31:0] mem [32];

    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference model state (one DUT with BOOT_CYCLES=1)
    logic [31:0] m_pc, m_instr, m_p4;
    logic        m_valid, m_fault;
    int          m_state, m_boot;

    always #5 clk = ~clk;

    assign imem_data  = mem[imem_addr[6:2]];
    assign imem_data2 = mem[imem_addr2[6:2]];

    if_fetch_stage #(.RESET_PC(32'h0), .IMEM_DEPTH(32), .BOOT_CYCLES(1)) u_dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect_en(redirect_en),
        .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_data(imem_data),
        .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc_plus4(ifid_pc_plus4),
        .fetch_fault(fetch_fault), .fetch_state(fetch_state)
    );

    if_fetch_stage #(.RESET_PC(32'h0), .IMEM_DEPTH(32), .BOOT_CYCLES(3)) u_dut3 (
        .clk(clk), .reset(reset), .stall(stall), .redirect_en(redirect_en),
        .redirect_pc(redirect_pc), .imem_addr(imem_addr2), .imem_data(imem_data2),
        .ifid_valid(ifid_valid2), .ifid_instr(ifid_instr2), .ifid_pc_plus4(ifid_pc_plus42),
        .fetch_fault(fetch_fault2), .fetch_state(fetch_state2)
    );

    typedef struct {
        logic        rst;
        logic        stl;
        logic        red;
        logic [31:0] rpc;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] p4;
        logic        fault;
        logic [1:0]  st;
    } vec_t;

    vec_t vecs [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Spec-level model: sequential fetch from a word array, with fault > redirect > stall priority.
    task automatic model_step(input logic r, input logic s, input logic re, input logic [31:0] rp);
        if (r) begin
            m_pc = 32'h0; m_state = 0; m_boot = 0;
            m_valid = 0; m_instr = 32'h0; m_p4 = 32'h0; m_fault = 0;
        end else if (m_state == 0) begin
            if (m_boot == 0) m_state = 1;
            m_boot++;
        end else if (m_state == 1) begin
            if ((m_pc % 4) != 0 || m_pc >= 32'd128) begin
                m_fault = 1; m_valid = 0; m_instr = 32'h0; m_state = 2;
            end else if (re) begin
                m_pc = rp; m_valid = 0; m_instr = 32'h0;
            end else if (!s) begin
                m_instr = mem[m_pc / 4]; m_p4 = m_pc + 4; m_valid = 1; m_pc = m_pc + 4;
            end
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic re, input logic [31:0] rp);
        @(negedge clk);
        reset = r; stall = s; redirect_en = re; redirect_pc = rp;
        model_step(r, s, re, rp);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, " addr"},  imem_addr, m_pc);
        check({tag, " valid"}, 32'(ifid_valid), 32'(m_valid));
        check({tag, " instr"}, ifid_instr, m_instr);
        check({tag, " pc4"},   ifid_pc_plus4, m_p4);
        check({tag, " fault"}, 32'(fetch_fault), 32'(m_fault));
        check({tag, " state"}, 32'(fetch_state), 32'(m_state));
    endtask

    function automatic vec_t v(input logic r, input logic s, input logic re, input logic [31:0] rp,
                               input logic [31:0] a, input logic vl, input logic [31:0] in,
                               input logic [31:0] p4, input logic f, input logic [1:0] st);
        vec_t x;
        x.rst = r; x.stl = s; x.red = re; x.rpc = rp; x.addr = a; x.valid = vl;
        x.instr = in; x.p4 = p4; x.fault = f; x.st = st;
        return x;
    endfunction

    initial begin
        mem[0] = 32'h0000_0820; mem[1] = 32'h0000_1020;
        mem[2] = 32'h2009_0064; mem[3] = 32'h1029_0002;
        for (int k = 4; k < 32; k++) mem[k] = 32'h0100_0000 | k;
        reset = 1'b1; stall = 1'b0; redirect_en = 1'b0; redirect_pc = 32'h0;

        // Boot, stall, redirect, bad-redirect fault, HALT, end-of-memory fault, reset at pc=20
        vecs.push_back(v(1,0,0,0,   0,  0,0,      0,  0,0));
        vecs.push_back(v(0,0,0,0,   0,  0,0,      0,  0,1));
        vecs.push_back(v(0,0,0,0,   4,  1,mem[0], 4,  0,1));
        vecs.push_back(v(0,0,0,0,   8,  1,mem[1], 8,  0,1));
        vecs.push_back(v(0,1,0,0,   8,  1,mem[1], 8,  0,1));
        vecs.push_back(v(0,1,0,0,   8,  1,mem[1], 8,  0,1));
        vecs.push_back(v(0,1,0,0,   8,  1,mem[1], 8,  0,1));
        vecs.push_back(v(0,0,0,0,   12, 1,mem[2], 12, 0,1));
        vecs.push_back(v(0,1,1,12,  12, 0,0,      12, 0,1));
        vecs.push_back(v(0,0,0,0,   16, 1,mem[3], 16, 0,1));
        vecs.push_back(v(0,0,1,6,   6,  0,0,      16, 0,1));
        vecs.push_back(v(0,0,1,40,  6,  0,0,      16, 1,2));
        for (int k = 0; k < 10; k++)
            vecs.push_back(v(0,k[0],1,32'(k*4), 6, 0,0, 16, 1,2));
        vecs.push_back(v(1,0,0,0,   0,  0,0,      0,  0,0));
        vecs.push_back(v(0,0,0,0,   0,  0,0,      0,  0,1));
        vecs.push_back(v(0,0,1,112, 112,0,0,      0,  0,1));
        vecs.push_back(v(0,0,0,0,   116,1,mem[28],116,0,1));
        vecs.push_back(v(0,0,0,0,   120,1,mem[29],120,0,1));
        vecs.push_back(v(0,0,0,0,   124,1,mem[30],124,0,1));
        vecs.push_back(v(0,0,0,0,   128,1,mem[31],128,0,1));
        vecs.push_back(v(0,0,0,0,   128,0,0,      128,1,2));
        vecs.push_back(v(1,0,0,0,   0,  0,0,      0,  0,0));
        vecs.push_back(v(0,0,0,0,   0,  0,0,      0,  0,1));
        for (int k = 1; k <= 5; k++)
            vecs.push_back(v(0,0,0,0, 32'(k*4), 1, mem[k-1], 32'(k*4), 0,1));
        vecs.push_back(v(1,0,0,0,   0,  0,0,      0,  0,0));
        vecs.push_back(v(0,0,0,0,   0,  0,0,      0,  0,1));
        vecs.push_back(v(0,0,0,0,   4,  1,mem[0], 4,  0,1));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].stl, vecs[i].red, vecs[i].rpc);
            check($sformatf("vec%0d addr", i),  imem_addr, vecs[i].addr);
            check($sformatf("vec%0d valid", i), 32'(ifid_valid), 32'(vecs[i].valid));
            check($sformatf("vec%0d instr", i), ifid_instr, vecs[i].instr);
            check($sformatf("vec%0d pc4", i),   ifid_pc_plus4, vecs[i].p4);
            check($sformatf("vec%0d fault", i), 32'(fetch_fault), 32'(vecs[i].fault));
            check($sformatf("vec%0d state", i), 32'(fetch_state), 32'(vecs[i].st));
        end

        // BOOT ignores stall/redirect; the 3-cycle-boot instance stays in BOOT until its third edge
        drive(1, 0, 0, 0);
        check_model("boot rst");
        check("boot3 st0", 32'(fetch_state2), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            drive(0, 1, 1, 40);
            check_model($sformatf("boot e%0d", k));
            check($sformatf("boot3 st%0d", k), 32'(fetch_state2), (k == 3) ? 32'd1 : 32'd0);
            check($sformatf("boot3 addr%0d", k), imem_addr2, 32'h0);
        end
        drive(0, 0, 1, 44);
        check("boot3 redirect", imem_addr2, 32'd44);
        check("boot3 valid", 32'(ifid_valid2), 32'd0);

        // Randomized run against the model
        for (int c = 0; c < 600; c++) begin
            logic        r, s, re;
            logic [31:0] rp;
            r  = ($urandom_range(0, 39) == 0);
            s  = ($urandom_range(0, 3) == 0);
            re = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 7) == 0) rp = $urandom_range(0, 255);
            else rp = 32'($urandom_range(0, 31) * 4);
            drive(r, s, re, rp);
            check_model($sformatf("rnd%0d", c));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
